// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction memory req/ack, downstream valid/ready, redirect input.
// Latency: none (wires only).
// Backpressure: carried by mem_ack (memory side) and instr_ready (downstream side).
// Ports (master = fetch stage view):
//   mem_req/mem_addr out, mem_ack/mem_rdata in             -- instruction memory
//   instr_valid/instruction/instr_pc out, instr_ready in   -- decode/immediate extender
//   redirect_valid/redirect_pc in                          -- execute-stage branch/jump
//   misaligned out                                         -- sticky misaligned-target flag
interface instruction_fetch_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [31:0]     mem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            misaligned;

  modport master (
    output mem_req, mem_addr, instr_valid, instruction, instr_pc, misaligned,
    input  mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instruction, instr_pc, misaligned,
    output mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I multi-cycle fetch stage: owns the PC, reads instruction memory, holds the fetched word.
// Latency: ack in the request cycle gives instr_valid on the next cycle; 2 cycles/instr minimum.
// Backpressure: HOLD keeps instruction/instr_pc stable and mem_req low until instr_ready.
// Ports:
//   clk, reset          -- rising-edge clock, asynchronous active-high reset
//   bus (master)        -- memory req/ack, downstream valid/ready, redirect in, misaligned out
module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            squash, squash_nxt;
  logic [31:0]     instr_q, instr_nxt;
  logic [XLEN-1:0] instr_pc_q, instr_pc_nxt;
  logic            valid_q, valid_nxt;
  logic            misaligned_q, misaligned_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      squash       <= 1'b0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      squash       <= squash_nxt;
      instr_q      <= instr_nxt;
      instr_pc_q   <= instr_pc_nxt;
      valid_q      <= valid_nxt;
      misaligned_q <= misaligned_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    squash_nxt     = squash;
    instr_nxt      = instr_q;
    instr_pc_nxt   = instr_pc_q;
    valid_nxt      = valid_q;
    misaligned_nxt = misaligned_q;

    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (bus.mem_ack) begin
          if (squash || bus.redirect_valid) begin
            // Response belongs to a stale PC: drop it and re-request at the new PC.
            squash_nxt = 1'b0;
          end else begin
            instr_nxt    = bus.mem_rdata;
            instr_pc_nxt = pc;
            pc_nxt       = pc + XLEN'(4);
            valid_nxt    = 1'b1;
            state_nxt    = HOLD;
          end
        end else if (bus.redirect_valid) begin
          // The request already issued cannot be withdrawn; discard whatever it returns.
          squash_nxt = 1'b1;
        end
      end
      HOLD: begin
        // A redirect also leaves HOLD; the held word counts as not accepted.
        if (bus.instr_ready || bus.redirect_valid) begin
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides any sequential PC update made above.
    if (bus.redirect_valid) begin
      pc_nxt         = {bus.redirect_pc[XLEN-1:2], 2'b00};
      misaligned_nxt = (bus.redirect_pc[1:0] != 2'b00);
    end
  end

  assign bus.mem_req     = (state == FETCH);
  assign bus.mem_addr    = pc;
  assign bus.instruction = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.misaligned  = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  int   mem_lat = 2;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instruction_fetch_if #(.XLEN(32)) bus ();

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (a ^ 32'h5A5A0013);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.instr_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, bus.instr_valid, 1);
  endtask

  task automatic accept();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  // Memory model: latches the address when a request starts, answers mem_lat cycles later.
  initial begin
    logic        busy;
    logic [31:0] addr_l;
    int          cnt;
    busy = 1'b0;
    addr_l = '0;
    cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (reset) begin
        busy = 1'b0;
      end else begin
        if (!busy && bus.mem_req) begin
          busy = 1'b1;
          addr_l = bus.mem_addr;
          cnt = 0;
        end
        if (busy) begin
          if (cnt == mem_lat) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = mem_fn(addr_l);
            busy = 1'b0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  // Scoreboard: every accepted instruction must match the next expected PC and its memory word.
  always @(negedge clk) begin
    if (!reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", bus.instr_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", bus.instr_pc, e);
        chk("sb_instr", bus.instruction, mem_fn(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 32'h100);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instruction, 0);
    chk("rst_ipc", bus.instr_pc, 0);
    chk("rst_mis", bus.misaligned, 0);

    // First fetch after reset release
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("idle_req", bus.mem_req, 0);
    exp_q.push_back(32'h100);
    step();
    chk("first_req", bus.mem_req, 1);
    chk("first_addr", bus.mem_addr, 32'h100);
    repeat (3) step();
    chk("first_valid", bus.instr_valid, 1);
    chk("first_instr", bus.instruction, 32'h00500093);
    chk("first_ipc", bus.instr_pc, 32'h100);
    chk("first_next", bus.mem_addr, 32'h104);

    // Backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", bus.instr_valid, 1);
      chk("bp_instr", bus.instruction, 32'h00500093);
      chk("bp_ipc", bus.instr_pc, 32'h100);
      chk("bp_req", bus.mem_req, 0);
    end
    accept();
    chk("acc_valid", bus.instr_valid, 0);
    chk("acc_req", bus.mem_req, 1);
    chk("acc_addr", bus.mem_addr, 32'h104);

    // Sequential fetch, then redirect one cycle before the 0x108 response
    exp_q.push_back(32'h104);
    wait_valid("wv_104");
    chk("ipc_104", bus.instr_pc, 32'h104);
    chk("pc_plus4", bus.mem_addr, 32'h108);
    accept();
    chk("addr_108", bus.mem_addr, 32'h108);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    step();
    bus.redirect_valid = 1'b0;
    chk("sq_req", bus.mem_req, 1);
    chk("sq_addr", bus.mem_addr, 32'h300);
    chk("sq_valid", bus.instr_valid, 0);
    exp_q.push_back(32'h300);
    repeat (3) begin
      step();
      chk("sq_novalid", bus.instr_valid, 0);
    end
    step();
    chk("sq_deliver", bus.instr_valid, 1);
    chk("sq_ipc", bus.instr_pc, 32'h300);
    chk("sq_mis", bus.misaligned, 0);
    accept();

    // Redirect in HOLD with instr_ready high the same cycle
    wait_valid("wv_304");
    chk("ipc_304", bus.instr_pc, 32'h304);
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("rh_valid", bus.instr_valid, 0);
    chk("rh_req", bus.mem_req, 1);
    chk("rh_addr", bus.mem_addr, 32'h200);
    exp_q.push_back(32'h200);
    wait_valid("wv_200");
    chk("ipc_200", bus.instr_pc, 32'h200);
    accept();

    // Misaligned redirect near the top of memory, then PC wrap
    wait_valid("wv_204");
    chk("ipc_204", bus.instr_pc, 32'h204);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    step();
    bus.redirect_valid = 1'b0;
    chk("mis_set", bus.misaligned, 1);
    chk("mis_addr", bus.mem_addr, 32'hFFFF_FFFC);
    chk("mis_valid", bus.instr_valid, 0);
    exp_q.push_back(32'hFFFF_FFFC);
    wait_valid("wv_top");
    chk("ipc_top", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", bus.mem_addr, 32'h0);
    chk("mis_sticky", bus.misaligned, 1);
    accept();
    chk("wrap_req", bus.mem_req, 1);
    chk("wrap_req_addr", bus.mem_addr, 32'h0);
    wait_valid("wv_zero");
    chk("ipc_zero", bus.instr_pc, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    chk("mis_clr", bus.misaligned, 0);
    chk("al_addr", bus.mem_addr, 32'h40);
    chk("al_req", bus.mem_req, 1);

    // Asynchronous reset in the middle of a FETCH cycle
    #2 reset = 1'b1;
    #1;
    chk("ar_req", bus.mem_req, 0);
    chk("ar_addr", bus.mem_addr, 32'h100);
    chk("ar_valid", bus.instr_valid, 0);
    chk("ar_instr", bus.instruction, 0);
    chk("ar_ipc", bus.instr_pc, 0);
    chk("ar_mis", bus.misaligned, 0);
    chk("sb_drained", exp_q.size(), 0);

    // Restart with a zero-latency memory: instr_valid one cycle after the request
    mem_lat = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back(32'h100);
    step();
    chk("rs_req", bus.mem_req, 1);
    chk("rs_addr", bus.mem_addr, 32'h100);
    step();
    chk("rs_valid", bus.instr_valid, 1);
    chk("rs_instr", bus.instruction, 32'h00500093);
    accept();
    chk("sb_final", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
